sprite_rom_arbiter: RTL and testbench
=====================================

SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 SHALL have parameter ROM_LATENCY, default 2, meaning cycles from rom_rd to valid rom_rdata (legal 1..4).
REQ-002 SHALL have parameter DATA_W, default 8, meaning palette-index width of one sprite pixel.
REQ-003 SHALL have port Clk  input  1  system clock; all state changes on rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports req_0 / req_1  input  1  per-requester fetch request (requester 0 = background layer, 1 = board/piece layer).
REQ-006 SHALL have ports idx_0 / idx_1  input  6  sprite index; row_0 / row_1  input  5  pixel row in tile; col_0 / col_1  input  5  pixel column in tile.
REQ-007 SHALL have ports gnt_0 / gnt_1  output  1  request accepted this cycle.
REQ-008 SHALL have ports rvalid_0 / rvalid_1  output  1  response strobe; rdata_0 / rdata_1  output  DATA_W  pixel data; err_0 / err_1  output  1  out-of-range flag, valid with rvalid.
REQ-009 SHALL have ports rom_rd  output  1  ROM read strobe; rom_addr  output  15  ROM address; rom_rdata  input  DATA_W  ROM data.

Function
REQ-010 SHALL accept at most one request per cycle; gnt_x combinational from req_x and registered priority pointer.
REQ-011 SHALL, when only one req is high, grant it regardless of pointer.
REQ-012 SHALL, when both req high, grant the requester not granted most recently (round-robin); pointer reset value favours requester 0.
REQ-013 SHALL update pointer only on a cycle with a grant; idle cycles leave it unchanged.
REQ-014 SHALL compute address = idx*400 + row*20 + col in at least 15-bit unsigned arithmetic, truncated to 15 bits (max legal 45*400+399 = 18399).
REQ-015 SHALL classify request out-of-range if idx > 45, row > 19 or col > 19.
REQ-016 SHALL, for grant on cycle T of an in-range request, drive rom_rd=1 and rom_addr registered on cycle T+1.
REQ-017 SHALL, for out-of-range grant, keep rom_rd=0 on T+1 (rom_addr holds previous value) yet still produce a response.
REQ-018 SHALL carry {valid, requester id, err} through a tag shift pipeline of depth ROM_LATENCY+1 aligned with ROM data.
REQ-019 SHALL register response: rvalid_x, rdata_x, err_x asserted for exactly one cycle at T+2+ROM_LATENCY (cycle T+4 at default), only for the granted requester.
REQ-020 SHALL drive rdata_x = 0 and err_x = 1 on out-of-range responses; err_x = 0 on in-range responses.
REQ-021 SHALL hold rdata_x and err_x at last response value when rvalid_x = 0.
REQ-022 SHALL sustain back-to-back grants every cycle with no bubbles; responses return in grant order.
REQ-023 SHALL keep rvalid_0 and rvalid_1 mutually exclusive in every cycle.
REQ-024 SHALL ignore idx/row/col of a requester not granted that cycle; requester must hold req and operands until gnt.

Reset
REQ-025 SHALL on Reset=1 asynchronously clear gnt-pointer (favour 0), tag pipeline, rom_rd, rom_addr, rvalid_x, rdata_x, err_x to 0.
REQ-026 SHALL drop all in-flight responses when Reset asserts mid-operation; no rvalid may appear after Reset deasserts for pre-reset grants.
REQ-027 SHALL hold gnt_x = 0 while Reset = 1.

Verification
REQ-028 Single read: req_0 with idx=18,row=3,col=7 for one cycle -> gnt_0 same cycle; rom_rd=1, rom_addr=7267 next cycle; rvalid_0 with ROM byte 4 cycles after grant, err_0=0.
REQ-029 Contention: req_0 and req_1 held high 4 cycles from reset -> grants alternate 0,1,0,1; four responses in same order, one per cycle.
REQ-030 Out-of-range: req_1 idx=46,row=0,col=0 -> gnt_1, rom_rd stays 0, rvalid_1=1 at T+4 with rdata_1=0, err_1=1; same for row=20, col=25.
REQ-031 Boundary: idx=45,row=19,col=19 -> rom_addr=18399, err=0; idx=0,row=0,col=0 -> rom_addr=0.
REQ-032 Reset mid-flight: grant 3 requests, assert Reset 2 cycles later -> all outputs 0 immediately; no rvalid after release; next request granted to requester 0 on contention.
REQ-033 Latency sweep: repeat REQ-028 with ROM_LATENCY=1 and 4 -> rvalid at T+3 and T+6 respectively.

Source files
------------

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: round-robin arbiter sharing one pipelined sprite ROM between two layers,
// with a tag pipeline that routes each ROM byte back to the requester that asked for it.
module sprite_rom_arbiter #(
    parameter int ROM_LATENCY = 2,
    parameter int DATA_W = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req_0,
    input  logic              req_1,
    input  logic [5:0]        idx_0,
    input  logic [5:0]        idx_1,
    input  logic [4:0]        row_0,
    input  logic [4:0]        row_1,
    input  logic [4:0]        col_0,
    input  logic [4:0]        col_1,
    output logic              gnt_0,
    output logic              gnt_1,
    output logic              rvalid_0,
    output logic              rvalid_1,
    output logic [DATA_W-1:0] rdata_0,
    output logic [DATA_W-1:0] rdata_1,
    output logic              err_0,
    output logic              err_1,
    output logic              rom_rd,
    output logic [14:0]       rom_addr,
    input  logic [DATA_W-1:0] rom_rdata
);
    logic ptr, gnt, oor;
    logic [5:0] idx;
    logic [4:0] row, col;
    logic [14:0] addr;
    logic [ROM_LATENCY:0] tv, tid, terr;
    // ptr names the requester that wins the next tie
    always_comb begin
        gnt_0 = ~Reset & req_0 & (~req_1 | ~ptr);
        gnt_1 = ~Reset & req_1 & (~req_0 | ptr);
        gnt = gnt_0 | gnt_1;
        idx = gnt_1 ? idx_1 : idx_0;
        row = gnt_1 ? row_1 : row_0;
        col = gnt_1 ? col_1 : col_0;
        oor = (idx > 6'd45) | (row > 5'd19) | (col > 5'd19);
        addr = 15'(idx) * 15'd400 + 15'(row) * 15'd20 + 15'(col);
    end
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ptr <= 1'b0;
            rom_rd <= 1'b0;
            rom_addr <= '0;
            tv <= '0;
            tid <= '0;
            terr <= '0;
            rvalid_0 <= 1'b0;
            rvalid_1 <= 1'b0;
            rdata_0 <= '0;
            rdata_1 <= '0;
            err_0 <= 1'b0;
            err_1 <= 1'b0;
        end else begin
            if (gnt)
                ptr <= ~gnt_1;
            rom_rd <= gnt & ~oor;
            if (gnt & ~oor)
                rom_addr <= addr;
            tv <= {tv[ROM_LATENCY-1:0], gnt};
            tid <= {tid[ROM_LATENCY-1:0], gnt_1};
            terr <= {terr[ROM_LATENCY-1:0], oor};
            // last tag stage lines up with the ROM byte for that request
            rvalid_0 <= tv[ROM_LATENCY] & ~tid[ROM_LATENCY];
            rvalid_1 <= tv[ROM_LATENCY] & tid[ROM_LATENCY];
            if (tv[ROM_LATENCY] & ~tid[ROM_LATENCY]) begin
                rdata_0 <= terr[ROM_LATENCY] ? '0 : rom_rdata;
                err_0 <= terr[ROM_LATENCY];
            end
            if (tv[ROM_LATENCY] & tid[ROM_LATENCY]) begin
                rdata_1 <= terr[ROM_LATENCY] ? '0 : rom_rdata;
                err_1 <= terr[ROM_LATENCY];
            end
        end
    end
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter: three arbiters (ROM latency 1, 2, 4) on shared stimulus, each checked
// against a scoreboard of expected responses keyed by the cycle they must appear on.
module tb_sprite_rom_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_0 = 1'b0, req_1 = 1'b0;
    logic [5:0] idx_0 = '0, idx_1 = '0;
    logic [4:0] row_0 = '0, row_1 = '0, col_0 = '0, col_1 = '0;
    logic [2:0] g0, g1, rv0, rv1, e0, e1, rd;
    logic [7:0] d0[3], d1[3], rrd[3];
    logic [14:0] ra[3];
    int errors = 0, checks = 0;
    always #5 clk = ~clk;

    function automatic logic [7:0] romfn(input logic [14:0] a);
        logic [14:0] t;
        t = (a * 15'd37) ^ (a >> 3);
        return t[7:0] ^ t[14:7];
    endfunction

    function automatic int lat(input int k);
        return k == 0 ? 1 : k == 1 ? 2 : 4;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : lane
        localparam int L = g == 0 ? 1 : g == 1 ? 2 : 4;
        logic [14:0] pipe[4];
        sprite_rom_arbiter #(.ROM_LATENCY(L), .DATA_W(8)) dut (
            .Clk(clk), .Reset(rst),
            .req_0(req_0), .req_1(req_1),
            .idx_0(idx_0), .idx_1(idx_1),
            .row_0(row_0), .row_1(row_1),
            .col_0(col_0), .col_1(col_1),
            .gnt_0(g0[g]), .gnt_1(g1[g]),
            .rvalid_0(rv0[g]), .rvalid_1(rv1[g]),
            .rdata_0(d0[g]), .rdata_1(d1[g]),
            .err_0(e0[g]), .err_1(e1[g]),
            .rom_rd(rd[g]), .rom_addr(ra[g]),
            .rom_rdata(rrd[g])
        );
        // ROM returns data for the address presented L cycles earlier
        always @(posedge clk) begin
            pipe[0] <= ra[g];
            for (int i = 1; i < 4; i++)
                pipe[i] <= pipe[i-1];
        end
        assign rrd[g] = romfn(pipe[L-1]);
    end

    bit p0, p1, pref, exp_rd, rnd;
    logic [5:0] pi0, pi1;
    logic [4:0] pr0, pr1, pc0, pc1;
    logic [14:0] exp_addr;
    int cyc;
    bit sv[3][16], sid[3][16], serr[3][16];
    logic [7:0] sd[3][16];
    logic [7:0] hd0[3], hd1[3];
    bit he0[3], he1[3];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %0d expected %0d", tag, cyc, act, exp);
        end
    endtask

    task automatic set0(input int i, input int r, input int c);
        p0 = 1; pi0 = 6'(i); pr0 = 5'(r); pc0 = 5'(c);
    endtask

    task automatic set1(input int i, input int r, input int c);
        p1 = 1; pi1 = 6'(i); pr1 = 5'(r); pc1 = 5'(c);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int s = 0; s < 16; s++) sv[k][s] = 0;
            hd0[k] = 0; hd1[k] = 0; he0[k] = 0; he1[k] = 0;
        end
        pref = 0; exp_rd = 0; exp_addr = 0;
    endtask

    task automatic check_zero(input string tag);
        for (int k = 0; k < 3; k++) begin
            check({tag, "_gnt"}, {g0[k], g1[k], rv0[k], rv1[k], e0[k], e1[k], rd[k]}, 0);
            check({tag, "_data"}, {d0[k], d1[k]}, 0);
            check({tag, "_addr"}, ra[k], 0);
        end
    endtask

    // ungranted requesters see random operands, which the DUT must ignore
    task automatic drive();
        req_0 = p0; req_1 = p1;
        idx_0 = p0 ? pi0 : 6'($urandom); row_0 = p0 ? pr0 : 5'($urandom); col_0 = p0 ? pc0 : 5'($urandom);
        idx_1 = p1 ? pi1 : 6'($urandom); row_1 = p1 ? pr1 : 5'($urandom); col_1 = p1 ? pc1 : 5'($urandom);
    endtask

    task automatic tick();
        bit gg0, gg1, oor;
        logic [5:0] i;
        logic [4:0] r, c;
        int a, s, t;
        if (rnd && !p0 && $urandom_range(3) != 0)
            set0($urandom_range(47), $urandom_range(21), $urandom_range(25));
        if (rnd && !p1 && $urandom_range(3) != 0)
            set1($urandom_range(47), $urandom_range(21), $urandom_range(25));
        drive();
        @(negedge clk);
        gg0 = p0 && (!p1 || !pref);
        gg1 = p1 && (!p0 || pref);
        s = cyc % 16;
        for (int k = 0; k < 3; k++) begin
            check("gnt_0", g0[k], gg0);
            check("gnt_1", g1[k], gg1);
            check("rom_rd", rd[k], exp_rd);
            check("rom_addr", ra[k], exp_addr);
            check("rvalid_0", rv0[k], sv[k][s] && !sid[k][s]);
            check("rvalid_1", rv1[k], sv[k][s] && sid[k][s]);
            if (sv[k][s] && !sid[k][s]) begin hd0[k] = sd[k][s]; he0[k] = serr[k][s]; end
            if (sv[k][s] && sid[k][s]) begin hd1[k] = sd[k][s]; he1[k] = serr[k][s]; end
            check("rdata_0", d0[k], hd0[k]);
            check("err_0", e0[k], he0[k]);
            check("rdata_1", d1[k], hd1[k]);
            check("err_1", e1[k], he1[k]);
            sv[k][s] = 0;
        end
        if (gg0 || gg1) begin
            i = gg1 ? pi1 : pi0;
            r = gg1 ? pr1 : pr0;
            c = gg1 ? pc1 : pc0;
            a = int'(i) * 400 + int'(r) * 20 + int'(c);
            oor = i > 45 || r > 19 || c > 19;
            for (int k = 0; k < 3; k++) begin
                t = (cyc + 2 + lat(k)) % 16;
                sv[k][t] = 1; sid[k][t] = gg1; serr[k][t] = oor;
                sd[k][t] = oor ? 8'd0 : romfn(15'(a));
            end
            exp_rd = !oor;
            if (!oor) exp_addr = 15'(a);
            pref = !gg1;
            if (gg1) p1 = 0; else p0 = 0;
        end else
            exp_rd = 0;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1;
        rst = 0;
        check("addr_formula", 18 * 400 + 3 * 20 + 7, 7267);
        // contention from reset: 0,1,0,1
        for (int n = 0; n < 4; n++) begin
            if (!p0) set0($urandom_range(45), $urandom_range(19), $urandom_range(19));
            if (!p1) set1($urandom_range(45), $urandom_range(19), $urandom_range(19));
            tick();
        end
        p0 = 0; p1 = 0;
        repeat (7) tick();
        set0(18, 3, 7);
        repeat (7) tick();
        set1(46, 0, 0); tick();
        set1(0, 20, 0); tick();
        set1(0, 0, 25); tick();
        repeat (6) tick();
        set0(45, 19, 19); tick();
        set0(0, 0, 0); tick();
        repeat (6) tick();
        rnd = 1;
        repeat (300) tick();
        rnd = 0;
        // three grants in flight, then reset two cycles later
        set0(10, 1, 2); set1(20, 3, 4); tick();
        set0(30, 5, 6); tick();
        tick();
        tick();
        set0(1, 1, 1); set1(2, 2, 2);
        drive();
        #1 rst = 1;
        #1 check_zero("mid_rst");
        model_reset();
        @(negedge clk);
        check_zero("rst_hold");
        @(posedge clk);
        cyc++;
        #1;
        check_zero("rst_edge");
        rst = 0;
        repeat (10) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
